mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be:
- WORD_WIDTH, default 32, width of the requester data buses and data_out.
- TIMEOUT, default 16, maximum grant length in cycles (legal range 2..255).

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, synchronous active-low reset.
- req0, in, 1, requester 0 wants the shared resource.
- req1, in, 1, requester 1 wants the shared resource.
- data0, in, WORD_WIDTH, requester 0 payload.
- data1, in, WORD_WIDTH, requester 1 payload.
- res_done, in, 1, resource reports the current transaction complete.
- gnt0, out, 1, requester 0 owns the resource.
- gnt1, out, 1, requester 1 owns the resource.
- select, out, 1, registered 2:1 data-mux select (0 = data0, 1 = data1).
- res_start, out, 1, one-cycle pulse marking the first cycle of a grant.
- data_out, out, WORD_WIDTH, selected payload to the resource.
- timeout_err, out, 1, one-cycle pulse after a grant is aborted by timeout.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, BUSY0, BUSY1.
REQ-004 In IDLE:
- gnt0 = gnt1 = 0; select holds its last value.
- If req0 or req1 is high, the next edge SHALL enter BUSYk for the arbitration winner k.
REQ-005 On entering BUSYk, on the same edge:
- gntk = 1 and select = k.
- res_start = 1 for that first BUSYk cycle only.
- The cycle counter is cleared to 0.
REQ-006 data_out SHALL be combinationally data1 when select = 1, else data0; zero added latency.
REQ-007 gnt0 and gnt1 SHALL never be high in the same cycle.
REQ-008 In BUSYk:
- The counter increments each cycle in which res_done is low.
- A drop of reqk is ignored; the grant persists until release.
REQ-009 Release occurs on the edge following a BUSYk cycle in which:
- res_done = 1, or
- the counter equals TIMEOUT-1 and res_done = 0.
REQ-010 At release, the FSM SHALL re-arbitrate the current req0/req1:
- A winner is granted directly (back-to-back, res_start pulses again).
- With no request, the FSM enters IDLE.
REQ-011 A timeout release SHALL assert timeout_err for exactly the one cycle following the last BUSY cycle; a grant therefore lasts at most TIMEOUT cycles.
REQ-012 res_done and the timeout condition in the same cycle SHALL be treated as done, with no timeout_err.
REQ-013 res_done coincident with res_start SHALL be accepted, giving a one-cycle grant.
REQ-014 res_done in IDLE SHALL be ignored.
REQ-015 When only one requester is active, it SHALL win regardless of arbitration mode.

Reset
REQ-016 While rst_n is sampled low at a clk edge, the block SHALL set:
- state = IDLE, counter = 0.
- gnt0 = gnt1 = 0, select = 0.
- res_start = 0, timeout_err = 0.
- last_gnt = 1.
REQ-017 Reset SHALL take priority over every other event, including mid-grant; no res_start or timeout_err SHALL be generated by a reset abort.
REQ-018 Requests held high through reset SHALL be granted on the second edge after rst_n is sampled high.

Configuration
REQ-019 Macro MEM_PORT_ARBITER_ROUND_ROBIN_EN selects the arbitration mode:
- Defined: register last_gnt records each winner; when both requesters are active, the one not equal to last_gnt wins. Requester 0 wins the first tie after reset.
- Undefined: requester 0 always wins a tie; last_gnt is not implemented.

Verification
REQ-020 Benches SHALL cover:
- Reset: req0 = req1 = 1 during rst_n = 0 -> all outputs 0. After rst_n is released, gnt0 = 1 and res_start = 1 on the second edge.
- Tie handling: req0 = req1 = 1 held, res_done pulsed 2 cycles after each res_start -> grants 0,1,0,1 with macro defined; 0,0,0,0 without.
- Data path: data0 = 0xAAAA0000, data1 = 0x00005555, req1 only -> select = 1, data_out = 0x00005555 while gnt1 = 1.
- Timeout: TIMEOUT = 4, req1 only, res_done = 0 -> gnt1 high for 4 cycles, then timeout_err high for 1 cycle. Repeat with res_done high in the 4th cycle -> no timeout_err.
- Reset mid-grant: rst_n = 0 during BUSY1 -> next edge gnt1 = 0, select = 0, no pulses.
- Short grant: res_done = 1 in the res_start cycle, req0 only -> gnt0 high exactly 1 cycle. If req0 is still high, gnt0 stays high and res_start pulses again.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose: arbitrates two requesters for one shared resource. A grant runs
// until the resource reports res_done or until the grant has lasted TIMEOUT
// cycles. At the end of a grant the arbiter re-arbitrates at once, so grants
// can run back to back. The payload of the granted requester is steered to
// data_out through a registered 2:1 select.
//
// Configuration macro:
//   MEM_PORT_ARBITER_ROUND_ROBIN_EN
//     Defined   : a tie goes to the requester that did not win last time.
//                 Requester 0 wins the first tie after reset.
//     Undefined : requester 0 always wins a tie.
//
// Parameters:
//   WORD_WIDTH  width of data0, data1 and data_out
//   TIMEOUT     maximum grant length in cycles (2..255)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   req0, req1   requests for the shared resource
//   data0, data1 requester payloads
//   res_done     resource reports the current transaction complete
//   gnt0, gnt1   grant to requester 0 / 1 (never both high)
//   select       registered data-mux select (0 = data0, 1 = data1)
//   res_start    one-cycle pulse in the first cycle of every grant
//   data_out     selected payload, combinational from select
//   timeout_err  one-cycle pulse in the cycle after a timed-out grant
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int WORD_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [WORD_WIDTH-1:0] data0,
  input  logic [WORD_WIDTH-1:0] data1,
  input  logic                  res_done,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  select,
  output logic                  res_start,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_e;

  // Counter value seen in the last cycle a grant may last.
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       select_q, select_d;
  logic       res_start_q, res_start_d;
  logic       timeout_err_q, timeout_err_d;
  // Set by the first edge that samples rst_n high. Arbitration is held off
  // until then, so requests held through reset are granted on the second
  // edge after reset is released.
  logic       ready_q;

  logic       any_req;
  logic       tie_pick;
  logic       winner;
  logic       grant_free;

`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
  logic last_gnt_q, last_gnt_d;
  // On a tie, the requester that did not win last time takes the grant.
  assign tie_pick = ~last_gnt_q;
`else
  assign tie_pick = 1'b0;
`endif

  assign any_req = req0 | req1;
  // A lone requester always wins; only a tie consults the arbitration mode.
  assign winner  = (req0 & req1) ? tie_pick : req1;

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave a value unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    select_d      = select_q;
    res_start_d   = 1'b0;
    timeout_err_d = 1'b0;
    grant_free    = 1'b0;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
    last_gnt_d    = last_gnt_q;
`endif

    case (state_q)
      IDLE: begin
        // res_done is ignored here; only requests matter.
        grant_free = ready_q;
      end
      default: begin
        // res_done wins over a coincident timeout: that is a normal finish.
        if (res_done) begin
          grant_free = 1'b1;
        end else if (cnt_q == LAST_CNT) begin
          grant_free    = 1'b1;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase

    // Re-arbitration happens on the same edge the previous grant ends, so a
    // waiting requester is granted without an idle cycle in between.
    if (grant_free) begin
      if (any_req) begin
        state_d     = winner ? BUSY1 : BUSY0;
        select_d    = winner;
        res_start_d = 1'b1;
        cnt_d       = 8'd0;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
        last_gnt_d  = winner;
`endif
      end else begin
        state_d = IDLE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      select_q      <= 1'b0;
      res_start_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      ready_q       <= 1'b0;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
      last_gnt_q    <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      select_q      <= select_d;
      res_start_q   <= res_start_d;
      timeout_err_q <= timeout_err_d;
      ready_q       <= 1'b1;
`ifdef MEM_PORT_ARBITER_ROUND_ROBIN_EN
      last_gnt_q    <= last_gnt_d;
`endif
    end
  end

  assign gnt0        = (state_q == BUSY0);
  assign gnt1        = (state_q == BUSY1);
  assign select      = select_q;
  assign res_start   = res_start_q;
  assign timeout_err = timeout_err_q;
  assign data_out    = select_q ? data1 : data0;

endmodule
